core_block_ctrl: RTL and testbench

Core-side responder of the block-dispatch protocol. The dispatcher drives `core_reset`, `core_start` and `core_block_id`; this block drives `core_done` back. On start it splits the block's threads across the core's warps, holds each warp active until that warp reports done, and then holds `core_done` until the dispatcher soft-resets the core. One instance sits at the top of every core, between the dispatcher and the warp schedulers.

---
 rtl/core_block_ctrl_if.sv | 27 ++
 rtl/core_block_ctrl.sv | 180 ++++++++++++++++++
 tb/tb_core_block_ctrl.sv | 342 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/core_block_ctrl_if.sv
// Dispatcher-to-core handshake bundle for core_block_ctrl.
// The dispatcher drives reset/start/block id/thread count; the core drives core_done back.
interface core_block_ctrl_if #(
    parameter int unsigned DATA_WIDTH = 8
);
    logic                  core_reset;
    logic                  core_start;
    logic [DATA_WIDTH-1:0] core_block_id;
    logic [DATA_WIDTH-1:0] threads_per_block;
    logic                  core_done;

    modport master (
        output core_reset,
        output core_start,
        output core_block_id,
        output threads_per_block,
        input  core_done
    );

    modport slave (
        input  core_reset,
        input  core_start,
        input  core_block_id,
        input  threads_per_block,
        output core_done
    );
endinterface

// File: rtl/core_block_ctrl.sv
// core_block_ctrl: core-side responder of the block-dispatch protocol.
// Splits a launched block's threads across the core's warps, tracks per-warp
// completion and holds core_done until the dispatcher soft-resets the core.
// Optional feature macro: CORE_CTRL_CYCLE_COUNT_EN adds a 32-bit block_cycles
// output counting RUN cycles (saturating, frozen in DONE).
module core_block_ctrl #(
    parameter int unsigned NUM_WARPS  = 4,
    parameter int unsigned WARP_SIZE  = 4,
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic                           clk,
    input  logic                           reset,
    core_block_ctrl_if.slave               disp,
    input  logic [NUM_WARPS-1:0]           warp_done,
    output logic [NUM_WARPS-1:0]           warp_active,
    output logic [DATA_WIDTH-1:0]          warp_block_id,
    output logic [NUM_WARPS*WARP_SIZE-1:0] warp_thread_mask
`ifdef CORE_CTRL_CYCLE_COUNT_EN
    ,
    output logic [31:0]                    block_cycles
`endif
);

    typedef logic [DATA_WIDTH-1:0] data_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LAUNCH,
        ST_RUN,
        ST_DONE
    } state_t;

    localparam int unsigned LANES = NUM_WARPS * WARP_SIZE;
    localparam data_t MAX_T = data_t'(LANES);
    localparam data_t WS_D  = data_t'(WARP_SIZE);

    state_t                 state_q, state_d;
    data_t                  threads_q, threads_d;
    data_t                  id_d;
    logic [NUM_WARPS-1:0]   active_d;
    logic [LANES-1:0]       mask_d;
    logic [NUM_WARPS-1:0]   req_q, req_d;
    logic [NUM_WARPS-1:0]   sticky_q, sticky_d;
    logic                   done_q, done_d;

    data_t                  t_clamp;
    data_t                  n_warps;
    logic [NUM_WARPS-1:0]   launch_active;
    logic [LANES-1:0]       launch_mask;
    logic [NUM_WARPS-1:0]   accepted;

`ifdef CORE_CTRL_CYCLE_COUNT_EN
    logic [31:0]            cnt_q, cnt_d;
    assign block_cycles = cnt_q;
`endif

    assign disp.core_done = done_q;

    // Launch geometry: clamp the thread count, then derive warp count and lane masks.
    // A lane is enabled when its global thread index is below the clamped count,
    // which yields full masks for leading warps and a partial mask for the last one.
    always_comb begin
        t_clamp       = (threads_q > MAX_T) ? MAX_T : threads_q;
        n_warps       = (t_clamp + WS_D - data_t'(1)) / WS_D;
        launch_active = '0;
        launch_mask   = '0;
        for (int unsigned i = 0; i < NUM_WARPS; i++) begin
            launch_active[i] = (data_t'(i) < n_warps);
            for (int unsigned j = 0; j < WARP_SIZE; j++) begin
                launch_mask[i*WARP_SIZE + j] = (data_t'(i*WARP_SIZE + j) < t_clamp);
            end
        end
    end

    // Next-state and next-output logic; soft reset takes priority in every state.
    always_comb begin
        state_d   = state_q;
        threads_d = threads_q;
        id_d      = warp_block_id;
        active_d  = warp_active;
        mask_d    = warp_thread_mask;
        req_d     = req_q;
        sticky_d  = sticky_q;
        done_d    = done_q;
        accepted  = warp_done & warp_active;
`ifdef CORE_CTRL_CYCLE_COUNT_EN
        cnt_d     = cnt_q;
`endif
        if (disp.core_reset) begin
            state_d  = ST_IDLE;
            active_d = '0;
            mask_d   = '0;
            sticky_d = '0;
            done_d   = 1'b0;
`ifdef CORE_CTRL_CYCLE_COUNT_EN
            cnt_d    = '0;
`endif
        end else begin
            case (state_q)
                ST_IDLE: begin
                    done_d = 1'b0;
                    if (disp.core_start) begin
                        id_d      = disp.core_block_id;
                        threads_d = disp.threads_per_block;
                        state_d   = ST_LAUNCH;
                    end
                end
                ST_LAUNCH: begin
                    active_d = launch_active;
                    mask_d   = launch_mask;
                    req_d    = launch_active;
                    sticky_d = '0;
`ifdef CORE_CTRL_CYCLE_COUNT_EN
                    cnt_d    = '0;
`endif
                    if (n_warps == '0) begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = ST_RUN;
                    end
                end
                ST_RUN: begin
                    sticky_d = sticky_q | accepted;
                    active_d = warp_active & ~accepted;
`ifdef CORE_CTRL_CYCLE_COUNT_EN
                    if (cnt_q != '1) cnt_d = cnt_q + 32'd1;
`endif
                    // Completion includes warps reporting in this very cycle.
                    if ((sticky_d & req_q) == req_q) begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                    end
                end
                ST_DONE: begin
                    done_d = 1'b1;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // Datapath and output registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            threads_q        <= '0;
            warp_block_id    <= '0;
            warp_active      <= '0;
            warp_thread_mask <= '0;
            req_q            <= '0;
            sticky_q         <= '0;
            done_q           <= 1'b0;
        end else begin
            threads_q        <= threads_d;
            warp_block_id    <= id_d;
            warp_active      <= active_d;
            warp_thread_mask <= mask_d;
            req_q            <= req_d;
            sticky_q         <= sticky_d;
            done_q           <= done_d;
        end
    end

`ifdef CORE_CTRL_CYCLE_COUNT_EN
    // RUN-cycle counter.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end
`endif

endmodule

// File: tb/tb_core_block_ctrl.sv
// Directed bench for core_block_ctrl (NUM_WARPS=4, WARP_SIZE=4, 8-bit data).
// Inputs change 1 time unit after the rising edge; outputs are checked there too.
module tb_core_block_ctrl;

    logic        clk;
    logic        reset;
    logic [3:0]  warp_done;
    logic [3:0]  warp_active;
    logic [7:0]  warp_block_id;
    logic [15:0] warp_thread_mask;
`ifdef CORE_CTRL_CYCLE_COUNT_EN
    logic [31:0] block_cycles;
`endif

    int checks;
    int failures;

    core_block_ctrl_if #(.DATA_WIDTH(8)) disp_if ();

    core_block_ctrl #(
        .NUM_WARPS (4),
        .WARP_SIZE (4),
        .DATA_WIDTH(8)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .disp            (disp_if),
        .warp_done       (warp_done),
        .warp_active     (warp_active),
        .warp_block_id   (warp_block_id),
        .warp_thread_mask(warp_thread_mask)
`ifdef CORE_CTRL_CYCLE_COUNT_EN
        ,
        .block_cycles    (block_cycles)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Dispatcher sequence: one core_reset cycle, a start cycle, then one more edge
    // so that LAUNCH has resolved when the task returns.
    task automatic do_launch(input logic [7:0] id, input logic [7:0] thr);
        disp_if.core_reset = 1'b1;
        tick();
        disp_if.core_reset        = 1'b0;
        disp_if.core_start        = 1'b1;
        disp_if.core_block_id     = id;
        disp_if.threads_per_block = thr;
        tick();
        disp_if.core_start = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        #2 reset = 1'b0;
        #1;
        checks++;
        if (warp_active !== 4'b0000 || warp_thread_mask !== 16'h0000 ||
            warp_block_id !== 8'h00 || disp_if.core_done !== 1'b0) begin
            failures++;
            $display("FAIL reset_outputs got active=%b mask=%h id=%h done=%b exp all zero",
                     warp_active, warp_thread_mask, warp_block_id, disp_if.core_done);
        end
        tick();
        tick();
        reset = 1'b1;
        tick();
    endtask

    task automatic test_uneven_split();
        do_launch(8'd3, 8'd10);
        checks++;
        if (warp_active !== 4'b0111) begin
            failures++;
            $display("FAIL t1_active got=%b exp=%b", warp_active, 4'b0111);
        end
        checks++;
        if (warp_thread_mask !== 16'h03FF) begin
            failures++;
            $display("FAIL t1_mask got=%h exp=%h", warp_thread_mask, 16'h03FF);
        end
        checks++;
        if (warp_block_id !== 8'd3) begin
            failures++;
            $display("FAIL t1_block_id got=%0d exp=3", warp_block_id);
        end
        warp_done = 4'b0100;
        tick();
        warp_done = 4'b0001;
        tick();
        warp_done = 4'b0000;
        tick();
        checks++;
        if (warp_active !== 4'b0010 || disp_if.core_done !== 1'b0) begin
            failures++;
            $display("FAIL t1_partial got active=%b done=%b exp active=0010 done=0",
                     warp_active, disp_if.core_done);
        end
        warp_done = 4'b0010;
        tick();
        warp_done = 4'b0000;
        checks++;
        if (disp_if.core_done !== 1'b1 || warp_active !== 4'b0000) begin
            failures++;
            $display("FAIL t1_done_rise got done=%b active=%b exp done=1 active=0000",
                     disp_if.core_done, warp_active);
        end
        disp_if.core_start = 1'b1;
        tick();
        tick();
        disp_if.core_start = 1'b0;
        checks++;
        if (disp_if.core_done !== 1'b1) begin
            failures++;
            $display("FAIL t1_done_held got=%b exp=1", disp_if.core_done);
        end
        disp_if.core_reset = 1'b1;
        tick();
        disp_if.core_reset = 1'b0;
        checks++;
        if (disp_if.core_done !== 1'b0 || warp_thread_mask !== 16'h0000 || warp_block_id !== 8'd3) begin
            failures++;
            $display("FAIL t1_soft_reset got done=%b mask=%h id=%0d exp done=0 mask=0000 id=3",
                     disp_if.core_done, warp_thread_mask, warp_block_id);
        end
    endtask

    task automatic test_zero_threads();
        disp_if.core_reset = 1'b1;
        tick();
        disp_if.core_reset        = 1'b0;
        disp_if.core_start        = 1'b1;
        disp_if.core_block_id     = 8'd5;
        disp_if.threads_per_block = 8'd0;
        tick();
        disp_if.core_start = 1'b0;
        checks++;
        if (disp_if.core_done !== 1'b0 || warp_active !== 4'b0000) begin
            failures++;
            $display("FAIL t2_after_T got done=%b active=%b exp done=0 active=0000",
                     disp_if.core_done, warp_active);
        end
        tick();
        checks++;
        if (disp_if.core_done !== 1'b1 || warp_active !== 4'b0000 || warp_thread_mask !== 16'h0000) begin
            failures++;
            $display("FAIL t2_after_T1 got done=%b active=%b mask=%h exp done=1 active=0000 mask=0000",
                     disp_if.core_done, warp_active, warp_thread_mask);
        end
`ifdef CORE_CTRL_CYCLE_COUNT_EN
        checks++;
        if (block_cycles !== 32'd0) begin
            failures++;
            $display("FAIL t2_cycles got=%0d exp=0", block_cycles);
        end
`endif
    endtask

    task automatic test_clamp();
        do_launch(8'd7, 8'd20);
        checks++;
        if (warp_active !== 4'b1111 || warp_thread_mask !== 16'hFFFF) begin
            failures++;
            $display("FAIL t3_launch got active=%b mask=%h exp active=1111 mask=ffff",
                     warp_active, warp_thread_mask);
        end
        warp_done = 4'b0001;
        tick();
        warp_done = 4'b0010;
        tick();
        warp_done = 4'b0100;
        tick();
        checks++;
        if (disp_if.core_done !== 1'b0 || warp_active !== 4'b1000) begin
            failures++;
            $display("FAIL t3_three_done got done=%b active=%b exp done=0 active=1000",
                     disp_if.core_done, warp_active);
        end
        warp_done = 4'b1000;
        tick();
        warp_done = 4'b0000;
        checks++;
        if (disp_if.core_done !== 1'b1) begin
            failures++;
            $display("FAIL t3_all_done got=%b exp=1", disp_if.core_done);
        end
    endtask

    task automatic test_back_to_back();
        do_launch(8'd1, 8'd8);
        checks++;
        if (warp_active !== 4'b0011 || warp_thread_mask !== 16'h00FF) begin
            failures++;
            $display("FAIL t4_launch got active=%b mask=%h exp active=0011 mask=00ff",
                     warp_active, warp_thread_mask);
        end
        warp_done = 4'b1000;
        tick();
        checks++;
        if (warp_active !== 4'b0011 || disp_if.core_done !== 1'b0) begin
            failures++;
            $display("FAIL t4_stray got active=%b done=%b exp active=0011 done=0",
                     warp_active, disp_if.core_done);
        end
        warp_done = 4'b1111;
        tick();
        warp_done = 4'b0000;
        checks++;
        if (disp_if.core_done !== 1'b1 || warp_active !== 4'b0000) begin
            failures++;
            $display("FAIL t4_same_cycle got done=%b active=%b exp done=1 active=0000",
                     disp_if.core_done, warp_active);
        end
    endtask

    task automatic test_abort();
        do_launch(8'd2, 8'd16);
        warp_done = 4'b0001;
        tick();
        disp_if.core_reset = 1'b1;
        warp_done          = 4'b0010;
        tick();
        disp_if.core_reset = 1'b0;
        warp_done          = 4'b0100;
        checks++;
        if (warp_active !== 4'b0000 || warp_thread_mask !== 16'h0000 ||
            disp_if.core_done !== 1'b0 || warp_block_id !== 8'd2) begin
            failures++;
            $display("FAIL t5_soft_abort got active=%b mask=%h done=%b id=%0d exp 0000 0000 0 2",
                     warp_active, warp_thread_mask, disp_if.core_done, warp_block_id);
        end
        tick();
        warp_done = 4'b0000;
        tick();
        checks++;
        if (warp_active !== 4'b0000 || disp_if.core_done !== 1'b0) begin
            failures++;
            $display("FAIL t5_late_done got active=%b done=%b exp active=0000 done=0",
                     warp_active, disp_if.core_done);
        end
        do_launch(8'd9, 8'd4);
        checks++;
        if (warp_active !== 4'b0001 || warp_thread_mask !== 16'h000F || warp_block_id !== 8'd9) begin
            failures++;
            $display("FAIL t5_relaunch got active=%b mask=%h id=%0d exp 0001 000f 9",
                     warp_active, warp_thread_mask, warp_block_id);
        end
        tick();
        reset = 1'b0;
        #1;
        checks++;
        if (warp_active !== 4'b0000 || warp_thread_mask !== 16'h0000 ||
            warp_block_id !== 8'd0 || disp_if.core_done !== 1'b0) begin
            failures++;
            $display("FAIL t5_async_reset got active=%b mask=%h id=%0d done=%b exp all zero",
                     warp_active, warp_thread_mask, warp_block_id, disp_if.core_done);
        end
        tick();
        reset = 1'b1;
        tick();
        do_launch(8'd4, 8'd5);
        checks++;
        if (warp_active !== 4'b0011 || warp_thread_mask !== 16'h001F || warp_block_id !== 8'd4) begin
            failures++;
            $display("FAIL t5_post_reset got active=%b mask=%h id=%0d exp 0011 001f 4",
                     warp_active, warp_thread_mask, warp_block_id);
        end
        warp_done = 4'b0011;
        tick();
        warp_done = 4'b0000;
        checks++;
        if (disp_if.core_done !== 1'b1) begin
            failures++;
            $display("FAIL t5_post_reset_done got=%b exp=1", disp_if.core_done);
        end
    endtask

`ifdef CORE_CTRL_CYCLE_COUNT_EN
    task automatic test_cycle_count();
        do_launch(8'd6, 8'd4);
        checks++;
        if (block_cycles !== 32'd0) begin
            failures++;
            $display("FAIL t6_cleared got=%0d exp=0", block_cycles);
        end
        for (int k = 1; k <= 6; k++) tick();
        warp_done = 4'b0001;
        tick();
        warp_done = 4'b0000;
        checks++;
        if (block_cycles !== 32'd7 || disp_if.core_done !== 1'b1) begin
            failures++;
            $display("FAIL t6_count got cycles=%0d done=%b exp cycles=7 done=1",
                     block_cycles, disp_if.core_done);
        end
        tick();
        tick();
        checks++;
        if (block_cycles !== 32'd7) begin
            failures++;
            $display("FAIL t6_frozen got=%0d exp=7", block_cycles);
        end
        disp_if.core_reset = 1'b1;
        tick();
        disp_if.core_reset = 1'b0;
        checks++;
        if (block_cycles !== 32'd0) begin
            failures++;
            $display("FAIL t6_reset_clear got=%0d exp=0", block_cycles);
        end
    endtask
`endif

    initial begin
        checks                    = 0;
        failures                  = 0;
        warp_done                 = 4'b0000;
        disp_if.core_reset        = 1'b0;
        disp_if.core_start        = 1'b0;
        disp_if.core_block_id     = 8'd0;
        disp_if.threads_per_block = 8'd0;
        test_reset();
        test_uneven_split();
        test_zero_threads();
        test_clamp();
        test_back_to_back();
        test_abort();
`ifdef CORE_CTRL_CYCLE_COUNT_EN
        test_cycle_count();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
